// File: rtl/native_initiator.sv
// native_initiator: turns one outstanding read/write command into handshakes on
// the native valid/ready memory bus (raddr/rdata/waddr/wdata) and returns a
// response holding the read data or a timeout error.
module native_initiator #(
  parameter int bus_width      = 32,
  parameter int timeout_cycles = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  // command side
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [bus_width-1:0] req_addr,
  input  logic [bus_width-1:0] req_wdata,
  // response side
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_write,
  output logic [bus_width-1:0] resp_rdata,
  output logic                 resp_err,
  // read address channel
  output logic                 raddr_valid,
  input  logic                 raddr_ready,
  output logic [bus_width-1:0] raddr,
  // read data channel
  input  logic                 rdata_valid,
  output logic                 rdata_ready,
  input  logic [bus_width-1:0] rdata,
  // write address channel
  output logic                 waddr_valid,
  input  logic                 waddr_ready,
  output logic [bus_width-1:0] waddr,
  // write data channel
  output logic                 wdata_valid,
  input  logic                 wdata_ready,
  output logic [bus_width-1:0] wdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Timeout limit in the 16-bit counter domain; zero turns the timeout off.
  localparam logic [15:0] TIMEOUT = 16'(timeout_cycles);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_req_ready;
  logic                 r_waddr_valid;
  logic                 r_wdata_valid;
  logic                 r_resp_write;
  logic                 r_resp_err;
  logic [bus_width-1:0] r_addr;
  logic [bus_width-1:0] r_wdata;
  logic [bus_width-1:0] r_resp_rdata;
  logic [15:0]          r_cnt;

  logic                 w_accept;
  logic                 w_busy;
  logic [15:0]          w_cnt_inc;
  logic                 w_timeout;
  logic                 w_rd_done;
  logic                 w_wr_done;
  logic                 w_err_set;

  assign w_accept  = r_req_ready && req_valid;
  assign w_busy    = (r_state == RD_ADDR) || (r_state == RD_DATA) || (r_state == WR);
  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_timeout = w_busy && (TIMEOUT != 16'd0) && (w_cnt_inc == TIMEOUT);
  assign w_rd_done = (r_state == RD_DATA) && rdata_valid;
  // A write is done once every channel still pending handshakes this cycle.
  assign w_wr_done = (r_state == WR) &&
                     (!r_waddr_valid || waddr_ready) &&
                     (!r_wdata_valid || wdata_ready);
  // A completion landing on the timeout edge takes priority over the error.
  assign w_err_set = w_timeout && !w_rd_done && !w_wr_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = req_write ? WR : RD_ADDR;
      RD_ADDR: begin
        if (w_timeout)        w_state_next = RESP;
        else if (raddr_ready) w_state_next = RD_DATA;
      end
      RD_DATA: if (rdata_valid || w_timeout) w_state_next = RESP;
      WR:      if (w_wr_done || w_timeout)   w_state_next = RESP;
      RESP:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Command latch, write-channel valids, timeout counter and response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready   <= 1'b0;
      r_waddr_valid <= 1'b0;
      r_wdata_valid <= 1'b0;
      r_resp_write  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_resp_rdata  <= '0;
      r_cnt         <= '0;
    end else begin
      r_req_ready <= (w_state_next == IDLE);
      if (w_busy) r_cnt <= w_cnt_inc;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr        <= req_addr;
            r_wdata       <= req_wdata;
            r_resp_write  <= req_write;
            r_resp_rdata  <= '0;
            r_resp_err    <= 1'b0;
            r_cnt         <= '0;
            r_waddr_valid <= req_write;
            r_wdata_valid <= req_write;
          end
        end
        RD_DATA: if (rdata_valid) r_resp_rdata <= rdata;
        WR: begin
          // Each channel drops on its own handshake and is never raised again.
          if (waddr_ready) r_waddr_valid <= 1'b0;
          if (wdata_ready) r_wdata_valid <= 1'b0;
        end
        default: ;
      endcase
      if (w_err_set) begin
        r_resp_err    <= 1'b1;
        r_resp_rdata  <= '0;
        r_waddr_valid <= 1'b0;
        r_wdata_valid <= 1'b0;
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign raddr_valid = (r_state == RD_ADDR);
  assign rdata_ready = (r_state == RD_DATA);
  assign resp_valid  = (r_state == RESP);
  assign waddr_valid = r_waddr_valid;
  assign wdata_valid = r_wdata_valid;
  assign raddr       = r_addr;
  assign waddr       = r_addr;
  assign wdata       = r_wdata;
  assign resp_write  = r_resp_write;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_native_initiator.sv
// tb_native_initiator: randomized and directed traffic through native_initiator
// against a delay-programmable memory responder, with a scoreboard monitor.
`timescale 1ns/1ps
module tb_native_initiator;

  localparam int W  = 32;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [W-1:0] req_addr, req_wdata;
  logic         resp_valid, resp_ready, resp_write, resp_err;
  logic [W-1:0] resp_rdata;
  logic         raddr_valid, raddr_ready;
  logic [W-1:0] raddr;
  logic         rdata_valid, rdata_ready;
  logic [W-1:0] rdata;
  logic         waddr_valid, waddr_ready;
  logic [W-1:0] waddr;
  logic         wdata_valid, wdata_ready;
  logic [W-1:0] wdata;

  always #5 clk = ~clk;

  native_initiator #(.bus_width(W), .timeout_cycles(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .raddr_valid(raddr_valid), .raddr_ready(raddr_ready), .raddr(raddr),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .waddr_valid(waddr_valid), .waddr_ready(waddr_ready), .waddr(waddr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata)
  );

  // expected response: lat is cycles from the accept cycle to the first
  // resp_valid cycle (-1 = not checked), rr is cycles resp_ready is held low
  typedef struct {
    logic        w;
    logic [31:0] d;
    logic        e;
    int          lat;
    int          acc;
    int          rr;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference memory (updated when a command is issued) and bus memory
  // (updated by the responder from what actually appears on the bus)
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- responder ----------------
  int          ra_dly = 0, rd_dly = 0, wa_dly = 0, wd_dly = 0;
  bit          stray = 1'b0;
  int          ra_cnt = 0, rd_cnt = 0, wa_cnt = 0, wd_cnt = 0;
  int          ra_len = 0, wa_len = 0, wd_len = 0;
  logic [31:0] rd_word = '0, wr_a = '0, wr_d = '0;
  bit          got_a = 1'b0, got_d = 1'b0;

  initial begin
    raddr_ready = 0; rdata_valid = 0; rdata = '0; waddr_ready = 0; wdata_ready = 0;
    forever begin
      @(negedge clk);
      if (raddr_valid) begin
        raddr_ready = (ra_cnt >= ra_dly);
        if (raddr_ready) rd_word = bus_rd(raddr);
        ra_cnt++;
      end else begin
        raddr_ready = 1'b0;
        if (ra_cnt > 0) ra_len = ra_cnt;
        ra_cnt = 0;
      end
      if (rdata_ready) begin
        rdata_valid = (rd_cnt >= rd_dly);
        rdata = rdata_valid ? rd_word : $urandom;
        rd_cnt++;
      end else begin
        rd_cnt = 0;
        rdata_valid = stray && raddr_valid;
        rdata = 32'hBAD;
      end
      if (waddr_valid) begin
        waddr_ready = (wa_cnt >= wa_dly);
        if (waddr_ready) begin wr_a = waddr; got_a = 1'b1; end
        wa_cnt++;
      end else begin
        waddr_ready = 1'b0;
        if (wa_cnt > 0) wa_len = wa_cnt;
        wa_cnt = 0;
      end
      if (wdata_valid) begin
        wdata_ready = (wd_cnt >= wd_dly);
        if (wdata_ready) begin wr_d = wdata; got_d = 1'b1; end
        wd_cnt++;
      end else begin
        wdata_ready = 1'b0;
        if (wd_cnt > 0) wd_len = wd_cnt;
        wd_cnt = 0;
      end
      if (got_a && got_d) begin
        bus_mem[wr_a] = wr_d;
        got_a = 1'b0; got_d = 1'b0;
      end
      if (!waddr_valid && !wdata_valid) begin got_a = 1'b0; got_d = 1'b0; end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int vcnt = 0;
  bit idle_chk = 1'b0;

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (idle_chk && !rst) chk("req_ready_after_resp", 32'(req_ready), 1);
      idle_chk = 1'b0;
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: resp_valid=1 with no command outstanding, required 0 (cycle %0d)", cyc);
          resp_ready = 1'b1;
        end else begin
          exp_t e;
          e = sbq[0];
          if (vcnt == 0 && e.lat >= 0) chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("resp_write", 32'(resp_write), 32'(e.w));
          chk("resp_rdata", resp_rdata, e.d);
          chk("resp_err", 32'(resp_err), 32'(e.e));
          chk("req_ready_in_resp", 32'(req_ready), 0);
          resp_ready = (vcnt >= e.rr);
          vcnt++;
          if (resp_ready) begin
            $display("[TB] resp w=%0d rdata=0x%08h err=%0d held=%0d", resp_write, resp_rdata, resp_err, vcnt);
            void'(sbq.pop_front());
            vcnt = 0;
            idle_chk = 1'b1;
          end
        end
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
        vcnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int ra, input int rd, input int wa, input int wd,
                      input int rr, input bit str, input int lat, input bit err);
    exp_t e;
    int   k;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    ra_dly = ra; rd_dly = rd; wa_dly = wa; wd_dly = wd; stray = str;
    k = 0;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL req_accept: req_ready=0 after 100 cycles, required 1");
      req_valid = 1'b0;
      return;
    end
    e.w = w; e.e = err; e.lat = lat; e.acc = cyc; e.rr = rr;
    if (err)    e.d = '0;
    else if (w) begin e.d = '0; ref_mem[a] = d; end
    else        e.d = ref_rd(a);
    sbq.push_back(e);
    $display("[TB] cmd %s addr=0x%08h wdata=0x%08h exp_rdata=0x%08h exp_err=%0d",
             w ? "WR" : "RD", a, d, e.d, err);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic wait_resp();
    int k = 0;
    while (sbq.size() != 0 && k < 200) begin @(negedge clk); k++; end
    if (sbq.size() != 0) begin
      tests++; fails++;
      $display("FAIL resp_wait: no response after 200 cycles, required a response");
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_req_ready"},   32'(req_ready),   0);
    chk({t, "_raddr_valid"}, 32'(raddr_valid), 0);
    chk({t, "_rdata_ready"}, 32'(rdata_ready), 0);
    chk({t, "_waddr_valid"}, 32'(waddr_valid), 0);
    chk({t, "_wdata_valid"}, 32'(wdata_valid), 0);
    chk({t, "_resp_valid"},  32'(resp_valid),  0);
    chk({t, "_raddr"},       raddr,            0);
    chk({t, "_waddr"},       waddr,            0);
    chk({t, "_wdata"},       wdata,            0);
    chk({t, "_resp_rdata"},  resp_rdata,       0);
    chk({t, "_resp_write"},  32'(resp_write),  0);
    chk({t, "_resp_err"},    32'(resp_err),    0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int          k;
    bit          w;
    logic [31:0] a, d;
    int          ra, rd, wa, wd, rr;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", 32'(req_ready), 1);

    // read of a known word with an always-ready responder
    ref_mem[32'h10] = 32'hDEADBEEF;
    bus_mem[32'h10] = 32'hDEADBEEF;
    send(0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    wait_resp();
    chk("rd_raddr_valid_len", 32'(ra_len), 1);

    // write with skewed readies, then read it back
    send(1, 32'h20, 32'h12345678, 0, 0, 0, 3, 0, 0, 5, 0);
    wait_resp();
    chk("wr_waddr_valid_len", 32'(wa_len), 1);
    chk("wr_wdata_valid_len", 32'(wd_len), 4);
    send(0, 32'h20, 0, 1, 1, 0, 0, 0, 0, 5, 0);
    wait_resp();

    // response backpressure for 5 cycles
    send(0, 32'h10, 0, 0, 0, 0, 0, 5, 0, 3, 0);
    wait_resp();

    // stray rdata_valid during the read-address phase
    send(0, 32'h20, 0, 3, 1, 0, 0, 0, 1, 7, 0);
    wait_resp();
    chk("stray_raddr_valid_len", 32'(ra_len), 4);

    // read address never accepted: timeout
    send(0, 32'h30, 0, 1000, 0, 0, 0, 0, 0, 9, 1);
    wait_resp();
    chk("to_raddr_valid_len", 32'(ra_len), 8);
    chk("to_raddr_valid_low", 32'(raddr_valid), 0);

    // read data on the timeout edge wins; one cycle later is an error
    send(0, 32'h40, 0, 0, 6, 0, 0, 0, 0, 9, 0);
    wait_resp();
    send(0, 32'h44, 0, 0, 7, 0, 0, 0, 0, 9, 1);
    wait_resp();

    // write data on the timeout edge wins; one cycle later is an error
    send(1, 32'h50, 32'hCAFEF00D, 0, 0, 0, 7, 0, 0, 9, 0);
    wait_resp();
    send(1, 32'h54, 32'h0BADF00D, 0, 0, 0, 8, 0, 0, 9, 1);
    wait_resp();
    chk("to_wdata_valid_len", 32'(wd_len), 8);
    send(0, 32'h50, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    wait_resp();

    // reset while waiting in the read-data phase: no response may follow
    send(0, 32'h60, 0, 0, 1000, 0, 0, 0, 0, -1, 0);
    k = 0;
    while (!rdata_ready && k < 20) begin @(negedge clk); k++; end
    chk("mid_read_rdata_ready", 32'(rdata_ready), 1);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk_reset("midreset");
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_midreset", 32'(req_ready), 1);
    repeat (6) @(negedge clk);

    // randomized traffic; delays stay well inside the timeout
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15)) * 32'd4;
      d  = $urandom;
      ra = $urandom_range(0, 2); rd = $urandom_range(0, 2);
      wa = $urandom_range(0, 2); wd = $urandom_range(0, 2);
      rr = $urandom_range(0, 3);
      send(w, a, d, ra, rd, wa, wd, rr, 1'($urandom_range(0, 1)),
           w ? 2 + ((wa > wd) ? wa : wd) : 3 + ra + rd, 0);
      wait_resp();
      if (w) begin
        chk("rand_waddr_valid_len", 32'(wa_len), 32'(wa + 1));
        chk("rand_wdata_valid_len", 32'(wd_len), 32'(wd + 1));
      end else begin
        chk("rand_raddr_valid_len", 32'(ra_len), 32'(ra + 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
